// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, bubble encoding and fetch-stage states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // FETCH: request outstanding for r_pc
    // READY: instruction parked in the buffer while the pipe is frozen
    // DROP : request for a stale PC still outstanding, redirect target queued
    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_READY = 2'd1,
        IF_DROP  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, presents instructions to IF/ID.
// Latency: zero-wait bypass -- data returned with ack is presented the same cycle.
// Backpressure: stall parks the returned word in a buffer and drops imem_req until released.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   stall                    IF/ID freeze from the hazard unit
//   branch, branch_target    redirect from ID (wins over stall and ack)
//   imem_req/addr/ack/rdata  instruction memory handshake; addr held until ack
//   pc_out, npc_out          PC of presented instruction and PC+4
//   instr_out, instr_valid   presented instruction and its qualifier
module if_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] npc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid
);

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_redir;

    logic        w_ack;
    logic        w_fetch_hit;
    logic        w_valid;
    logic [31:0] w_pc_inc;

    // READY and any unused encoding keep the request low/high respectively;
    // an illegal encoding behaves like FETCH until the next edge fixes it.
    assign imem_req  = (r_state != IF_READY);
    assign imem_addr = r_pc;

    // ack only means something while a request is actually out and not in reset
    assign w_ack       = imem_ack & imem_req & ~rst;
    assign w_fetch_hit = (r_state == IF_FETCH) & w_ack;
    assign w_valid     = ~rst & (w_fetch_hit | (r_state == IF_READY));
    assign w_pc_inc    = r_pc + 32'd4;

    assign instr_valid = w_valid;
    assign pc_out      = r_pc;
    assign npc_out     = w_valid ? w_pc_inc : NOP_INSTR;
    assign instr_out   = w_fetch_hit                ? imem_rdata :
                         (w_valid)                  ? r_buf      :
                                                      NOP_INSTR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IF_FETCH;
            r_pc    <= RESET_VECTOR;
            r_buf   <= NOP_INSTR;
            r_redir <= 32'h0;
        end else begin
            case (r_state)
                IF_FETCH: begin
                    if (branch) begin
                        if (w_ack) begin
                            // data arrived with the redirect: throw it away
                            r_pc    <= branch_target;
                            r_state <= IF_FETCH;
                        end else begin
                            // address must stay put until the memory answers
                            r_redir <= branch_target;
                            r_state <= IF_DROP;
                        end
                    end else if (w_ack) begin
                        if (stall) begin
                            r_buf   <= imem_rdata;
                            r_state <= IF_READY;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= IF_FETCH;
                        end
                    end
                end
                IF_READY: begin
                    if (branch) begin
                        r_pc    <= branch_target;
                        r_state <= IF_FETCH;
                    end else if (!stall) begin
                        r_pc    <= w_pc_inc;
                        r_state <= IF_FETCH;
                    end
                end
                IF_DROP: begin
                    if (branch && w_ack) begin
                        // newest target wins even on the cycle the stale data lands
                        r_pc    <= branch_target;
                        r_state <= IF_FETCH;
                    end else if (branch) begin
                        r_redir <= branch_target;
                    end else if (w_ack) begin
                        r_pc    <= r_redir;
                        r_state <= IF_FETCH;
                    end
                end
                default: begin
                    r_state <= IF_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  async active-high reset
  stall  in  1  hazard-unit freeze; IF/ID will not capture this cycle
  branch  in  1  taken branch/jump redirect from ID
  branch_target  in  32  redirect address, valid with branch
  imem_req  out  1  fetch request to instruction memory
  imem_addr  out  32  word address of request
  imem_ack  in  1  memory returns data this cycle (may be same cycle as req)
  imem_rdata  in  32  instruction word, valid with imem_ack
  pc_out  out  32  PC of presented instruction
  npc_out  out  32  pc_out+4, feeds IF/ID npc input
  instr_out  out  32  instruction, feeds IF/ID instr input
  instr_valid  out  1  instr_out/npc_out carry a real instruction

Function
REQ-003 States SHALL be FETCH (request outstanding), READY (instruction held in buffer), DROP (stale request outstanding, redirect pending).
REQ-004 imem_req SHALL be 1 in FETCH and DROP, 0 in READY; imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-005 imem_ack SHALL be ignored when imem_req=0.
REQ-006 In FETCH, imem_addr SHALL equal PC; in DROP it SHALL equal the stale PC, with the target held in a redirect register.
REQ-007 Presentation: FETCH with ack -> instr_out=imem_rdata, instr_valid=1 (combinational bypass); READY -> instr_out=buffer, instr_valid=1; all other cases -> instr_out=32'h0, npc_out=32'h0, instr_valid=0.
REQ-008 Consumption SHALL occur at an edge where instr_valid=1, stall=0 and branch=0; on consumption PC<=PC+4, and the state SHALL stay or become FETCH.
REQ-009 FETCH with ack and stall=1 and branch=0: imem_rdata SHALL be latched into the buffer, and the state SHALL become READY.
REQ-010 branch SHALL take priority over stall and over any ack.
REQ-011 branch in READY, or in FETCH with ack: PC<=branch_target, the instruction SHALL be discarded, and the state SHALL become FETCH.
REQ-012 branch in FETCH without ack: branch_target SHALL be latched into the redirect register, and the state SHALL become DROP.
REQ-013 branch in DROP: the redirect register SHALL be overwritten with the newest target.
REQ-014 DROP with ack: the returned data SHALL be discarded, PC<=redirect register, and the state SHALL become FETCH; instr_valid SHALL stay 0 throughout DROP.
REQ-015 PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 SHALL wrap to 0.
REQ-016 No illegal state SHALL be reachable; unused encodings SHALL return to FETCH.

Reset
REQ-017 While rst=1: PC=32'h00400000, state=FETCH, buffer=0, redirect=0.
REQ-018 While rst=1, outputs SHALL be imem_req=1, imem_addr=32'h00400000, instr_valid=0, instr_out=0, npc_out=0.
REQ-019 Reset asserted mid-request SHALL abandon that request; no data from it SHALL be presented after reset.

Structure
REQ-020 Shared package cpu_pkg SHALL hold RESET_VECTOR (32'h00400000), NOP_INSTR (32'h0) and the IF state enumeration.
REQ-021 The block SHALL be a single module with no sub-modules; the PC, buffer and redirect registers SHALL be internal.

Verification
REQ-022 Zero-wait memory (ack tied to req), no stall/branch -> instr_valid=1 every cycle; addresses 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; npc_out=0x00400004, 0x00400008, 0x0040000C.
REQ-023 Ack with stall=1 for 3 cycles -> READY; instr_out holds the word and imem_req=0; after stall drops, next imem_addr=PC+4.
REQ-024 Request at 0x00400010 with ack delayed 4 cycles; branch to 0x00400100 on cycle 2 -> DROP; ack data discarded; next imem_addr=0x00400100; instr_valid=0 until its ack.
REQ-025 branch and stall together while READY -> branch wins; next imem_addr=branch_target; buffer contents never presented.
REQ-026 PC=0xFFFFFFFC consumed -> next imem_addr=0x00000000; npc_out=0x00000000 for that instruction.
REQ-027 rst pulsed during an outstanding request with late ack -> after release imem_addr=0x00400000; the late ack data is never presented.
